// File: rtl/mac_feed_sequencer_if.sv
// MAC feed bus: weight beats (with group index) and feature beats (with Wout loop markers).
// Pure wiring, no latency of its own.
// No backpressure on this bus; the sequencer paces itself with acc_rdy.
interface mac_feed_sequencer_if #(
  parameter int WT_DW    = 256,
  parameter int DAT_DW   = 256,
  parameter int LOG2TOUT = 5
);
  logic                wt_vld;
  logic [WT_DW-1:0]    wt;
  logic [LOG2TOUT-1:0] wt_cnt;
  logic                dat_vld;
  logic [DAT_DW-1:0]   dat;
  logic                Wout_loop_start;
  logic                Wout_loop_end;

  modport master (
    output wt_vld, wt, wt_cnt, dat_vld, dat, Wout_loop_start, Wout_loop_end
  );

  modport slave (
    input  wt_vld, wt, wt_cnt, dat_vld, dat, Wout_loop_start, Wout_loop_end
  );
endinterface

// File: rtl/mac_feed_sequencer.sv
// Issues weight groups and Wout feature loops from the buffers to the MAC array, tile by tile.
// Buffer read to MAC beat is 1 cycle; done follows the last data read by 2 cycles.
// acc_rdy gates only the start of a Wout loop; issued groups and loops never stall.
// Optional build macro MAC_FEED_WT_PREFETCH_EN: overlap group k+1 with loop k.
module mac_feed_sequencer #(
  parameter int TOUT     = 32,
  parameter int LOG2TOUT = 5,
  parameter int WT_DW    = 256,
  parameter int DAT_DW   = 256,
  parameter int AW       = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       tile_num,
  input  logic [AW-1:0]     wout_num,
  input  logic [AW-1:0]     wt_base,
  input  logic [AW-1:0]     dat_base,
  input  logic              acc_rdy,
  output logic              busy,
  output logic              done,
  output logic              wt_rd_en,
  output logic [AW-1:0]     wt_rd_addr,
  input  logic [WT_DW-1:0]  wt_rd_data,
  output logic              dat_rd_en,
  output logic [AW-1:0]     dat_rd_addr,
  input  logic [DAT_DW-1:0] dat_rd_data,
  mac_feed_sequencer_if.master mac
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [15:0]         tile_q;
  logic [AW-1:0]       wout_q;
  logic [AW-1:0]       dat_base_q;
  logic [AW-1:0]       wt_addr;
  logic                wt_busy;     // a weight group is being read out
  logic [LOG2TOUT-1:0] wc;          // beat index inside the current group
  logic [15:0]         wg;          // weight groups fully issued
  logic [AW-1:0]       dc;          // beat index inside the current Wout loop
  logic [15:0]         dg;          // Wout loops fully issued
  logic                done_nxt;
  logic                job_go;
  logic                wt_last;
  logic                dat_first;
  logic                dat_last;
  logic                dat_loop_ok;
  logic                wt_trig;

  assign wt_last   = (wc == LOG2TOUT'(TOUT - 1));
  assign dat_first = (dc == '0);
  assign dat_last  = (dc == wout_q - 1'b1);
  // A new loop needs its own group fully read, the previous loop finished and the accumulator ready.
  assign dat_loop_ok = dat_first && acc_rdy && (wg > dg);

`ifdef MAC_FEED_WT_PREFETCH_EN
  // Next group starts right after the first read of the loop that consumes the current group.
  assign wt_trig = dat_rd_en && dat_first && (wg != tile_q);
`else
  // Next group waits until the current loop has issued its last read.
  assign wt_trig = dat_rd_en && dat_last && (wg != tile_q);
`endif

  assign busy        = (state != IDLE);
  assign wt_rd_addr  = wt_addr;
  assign dat_rd_addr = dat_base_q + dc;
  // Buffers return registered data one cycle after the read; gate it so idle outputs stay 0.
  assign mac.wt      = mac.wt_vld  ? wt_rd_data  : '0;
  assign mac.dat     = mac.dat_vld ? dat_rd_data : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, read enables and job start/finish decode.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    job_go    = 1'b0;
    wt_rd_en  = 1'b0;
    dat_rd_en = 1'b0;
    case (state)
      IDLE: begin
        // done high means the previous job just ended; a start in that cycle is dropped.
        if (start && !done) begin
          if (tile_num != 16'd0) begin
            state_nxt = RUN;
            job_go    = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        wt_rd_en  = wt_busy;
        dat_rd_en = !dat_first || dat_loop_ok;
        if (dat_rd_en && dat_last && (dg == tile_q - 16'd1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job parameters and weight/data issue counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_q     <= '0;
      wout_q     <= '0;
      dat_base_q <= '0;
      wt_addr    <= '0;
      wt_busy    <= 1'b0;
      wc         <= '0;
      wg         <= '0;
      dc         <= '0;
      dg         <= '0;
    end else if (job_go) begin
      tile_q     <= tile_num;
      wout_q     <= wout_num;
      dat_base_q <= dat_base;
      wt_addr    <= wt_base;
      wt_busy    <= 1'b1;
      wc         <= '0;
      wg         <= '0;
      dc         <= '0;
      dg         <= '0;
    end else if (state == RUN) begin
      if (wt_rd_en) begin
        wt_addr <= wt_addr + 1'b1;
        if (wt_last) begin
          wc      <= '0;
          wt_busy <= 1'b0;
          wg      <= wg + 16'd1;
        end else begin
          wc <= wc + 1'b1;
        end
      end
      if (wt_trig) wt_busy <= 1'b1;
      if (dat_rd_en) begin
        if (dat_last) begin
          dc <= '0;
          dg <= dg + 16'd1;
        end else begin
          dc <= dc + 1'b1;
        end
      end
    end
  end

  // MAC-side valids and sidebands, aligned with the returning read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac.wt_vld          <= 1'b0;
      mac.wt_cnt          <= '0;
      mac.dat_vld         <= 1'b0;
      mac.Wout_loop_start <= 1'b0;
      mac.Wout_loop_end   <= 1'b0;
      done                <= 1'b0;
    end else begin
      mac.wt_vld          <= wt_rd_en;
      mac.wt_cnt          <= wt_rd_en ? wc : '0;
      mac.dat_vld         <= dat_rd_en;
      mac.Wout_loop_start <= dat_rd_en && dat_first;
      mac.Wout_loop_end   <= dat_rd_en && dat_last;
      done                <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mac_feed_sequencer.sv
// Scoreboarded bench for mac_feed_sequencer with TOUT=4 and randomized jobs.
// Expected beats are queued per job; a negedge monitor pops and compares every MAC beat.
// Job timing (first reads, group overlap, done cycle) is checked against closed-form tile schedules.
module tb_mac_feed_sequencer;
  localparam int TOUT = 4;
  localparam int LG   = 2;
  localparam int DW   = 64;
  localparam int AW   = 12;
`ifdef MAC_FEED_WT_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   tile_num = '0;
  logic [AW-1:0] wout_num = '0, wt_base = '0, dat_base = '0;
  logic          acc_rdy = 1'b1;
  logic          busy, done, wt_rd_en, dat_rd_en;
  logic [AW-1:0] wt_rd_addr, dat_rd_addr;
  logic [DW-1:0] wt_rd_data = '0, dat_rd_data = '0;

  mac_feed_sequencer_if #(.WT_DW(DW), .DAT_DW(DW), .LOG2TOUT(LG)) mac ();

  mac_feed_sequencer #(.TOUT(TOUT), .LOG2TOUT(LG), .WT_DW(DW), .DAT_DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tile_num(tile_num), .wout_num(wout_num),
    .wt_base(wt_base), .dat_base(dat_base), .acc_rdy(acc_rdy), .busy(busy), .done(done),
    .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
    .dat_rd_en(dat_rd_en), .dat_rd_addr(dat_rd_addr), .dat_rd_data(dat_rd_data),
    .mac(mac)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic [LG-1:0] cnt; } wexp_t;
  typedef struct { logic [DW-1:0] d; logic s; logic e; } dexp_t;
  wexp_t wq[$];
  dexp_t dq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  function automatic logic [DW-1:0] wpat(input logic [AW-1:0] a);
    return {20'hABCDE, a, 20'h12345, a};
  endfunction

  function automatic logic [DW-1:0] dpat(input logic [AW-1:0] a);
    return {20'h5A5A5, a, 20'hF00D0, ~a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Buffers: registered read data, one cycle after the read enable.
  always @(posedge clk) begin
    if (wt_rd_en)  wt_rd_data  <= wpat(wt_rd_addr);
    if (dat_rd_en) dat_rd_data <= dpat(dat_rd_addr);
  end

  // Monitor: every MAC beat must match the head of its expected queue.
  always @(negedge clk) begin
    wexp_t we;
    dexp_t de;
    if (rst_n) begin
      if (mac.wt_vld && mac.dat_vld) overlap++;
      if (mac.wt_vld) begin
        if (wq.size() == 0) chk("wt_unexpected_beat", 1, 0);
        else begin
          we = wq.pop_front();
          chk("wt_data", mac.wt, we.d);
          chk("wt_cnt", 64'(mac.wt_cnt), 64'(we.cnt));
        end
      end
      if (mac.dat_vld) begin
        if (dq.size() == 0) chk("dat_unexpected_beat", 1, 0);
        else begin
          de = dq.pop_front();
          chk("dat_data", mac.dat, de.d);
          chk("loop_start", 64'(mac.Wout_loop_start), 64'(de.s));
          chk("loop_end", 64'(mac.Wout_loop_end), 64'(de.e));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_wt_rd_en"}, 64'(wt_rd_en), 0);
    chk({tag, "_dat_rd_en"}, 64'(dat_rd_en), 0);
    chk({tag, "_wt_vld"}, 64'(mac.wt_vld), 0);
    chk({tag, "_dat_vld"}, 64'(mac.dat_vld), 0);
    chk({tag, "_wt"}, mac.wt, 0);
    chk({tag, "_dat"}, mac.dat, 0);
    chk({tag, "_wt_cnt"}, 64'(mac.wt_cnt), 0);
    chk({tag, "_markers"}, 64'({mac.Wout_loop_start, mac.Wout_loop_end}), 0);
  endtask

  task automatic push_job(input int n, input int w, input int wb, input int db);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < TOUT; c++) wq.push_back('{wpat(AW'(wb + k * TOUT + c)), LG'(c)});
      for (int d = 0; d < w; d++) dq.push_back('{dpat(AW'(db + d)), d == 0, d == w - 1});
    end
  endtask

  // lo: cycles acc_rdy is held low starting when group 0 has just been read.
  task automatic run_job(input int n, input int w, input int wb, input int db, input int lo);
    int s0, step, exp_done, wt_reads, g1_start, first_dat, first_wvld, first_ls;
    int done_rel, done_cnt, quiet_bad, exp_ovl;
    s0       = TOUT + 1 + lo;
    step     = PF ? ((w > TOUT + 1) ? w : TOUT + 1) : (w + TOUT);
    exp_done = s0 + (n - 1) * step + w + 1;
    exp_ovl  = PF ? (n - 1) * ((w - 1 < TOUT) ? w - 1 : TOUT) : 0;
    wt_reads = 0; g1_start = -1; first_dat = -1; first_wvld = -1; first_ls = -1;
    done_rel = -1; done_cnt = 0; quiet_bad = 0;
    push_job(n, w, wb, db);
    @(posedge clk); #1;
    overlap  = 0;
    tile_num = 16'(n); wout_num = AW'(w); wt_base = AW'(wb); dat_base = AW'(db);
    start    = 1'b1;
    acc_rdy  = 1'b1;
    for (int rel = 1; rel <= exp_done + 3; rel++) begin
      @(posedge clk); #1;
      start   = 1'b0;
      acc_rdy = !(rel >= TOUT + 1 && rel < TOUT + 1 + lo);
      #1;
      if (wt_rd_en) begin
        wt_reads++;
        if (wt_reads == TOUT + 1) g1_start = rel;
      end
      if (dat_rd_en && first_dat < 0) first_dat = rel;
      if (mac.wt_vld && first_wvld < 0) first_wvld = rel;
      if (mac.Wout_loop_start && first_ls < 0) first_ls = rel;
      if (done) begin
        done_cnt++;
        if (done_rel < 0) done_rel = rel;
      end
      if (rel >= TOUT + 1 && rel <= TOUT + lo && (wt_rd_en || dat_rd_en)) quiet_bad++;
      if (rel >= TOUT + 2 && rel <= TOUT + lo &&
          (mac.wt_vld || mac.dat_vld || mac.Wout_loop_start || mac.Wout_loop_end || done))
        quiet_bad++;
    end
    chk("first_wt_vld_cycle", first_wvld, 2);
    chk("first_dat_read_cycle", first_dat, s0);
    chk("first_loop_start_cycle", first_ls, s0 + 1);
    chk("done_cycle", done_rel, exp_done);
    chk("done_pulse_count", done_cnt, 1);
    chk("busy_after_done", 64'(busy), 0);
    chk("wt_read_total", wt_reads, n * TOUT);
    chk("wt_dat_overlap_cycles", overlap, exp_ovl);
    if (n >= 2) chk("group1_start_cycle", g1_start, s0 + (PF ? 1 : w));
    if (lo > 0) chk("acc_stall_quiet", quiet_bad, 0);
    chk("wt_queue_drained", wq.size(), 0);
    chk("dat_queue_drained", dq.size(), 0);
    wq.delete();
    dq.delete();
  endtask

  initial begin
    int n, w, wb, db, lo, done_seen;
    #12;
    check_all_zero("reset");
    #10 rst_n = 1'b1;

    run_job(1, 3, 0, 0, 0);
    run_job(3, 8, 0, 0, 0);
    run_job(2, 1, 100, 200, 0);
    run_job(3, 1, 7, 9, 0);
    run_job(2, 3, 16, 32, 10);
    for (int j = 0; j < 8; j++) begin
      n  = $urandom_range(1, 4);
      w  = $urandom_range(1, 7);
      wb = $urandom_range(0, 4000);
      db = $urandom_range(0, 4000);
      lo = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : 0;
      run_job(n, w, wb, db, lo);
    end

    // Reset in the middle of loop 0: everything drops at once, no done afterwards.
    push_job(2, 5, 40, 60);
    @(posedge clk); #1;
    tile_num = 16'd2; wout_num = AW'(5); wt_base = AW'(40); dat_base = AW'(60);
    start = 1'b1; acc_rdy = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    wq.delete();
    dq.delete();
    done_seen = 0;
    repeat (2) begin
      @(posedge clk); #2;
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #2;
      if (done || busy || wt_rd_en || dat_rd_en) done_seen++;
    end
    chk("midreset_no_done_or_activity", done_seen, 0);

    // Empty job: done the next cycle, no reads; a start coinciding with done is dropped.
    @(posedge clk); #1;
    tile_num = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    tile_num = 16'd1; wout_num = AW'(2); start = 1'b1;
    #1;
    chk("zero_tile_done", 64'(done), 1);
    chk("zero_tile_no_wt_read", 64'(wt_rd_en), 0);
    chk("zero_tile_not_busy", 64'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    chk("start_on_done_ignored_busy", 64'(busy), 0);
    chk("start_on_done_ignored_done", 64'(done), 0);
    chk("start_on_done_no_wt_read", 64'(wt_rd_en), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_stays_idle", 64'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_feed_sequencer.md
# mac_feed_sequencer

Buffer-side issuer for the column-systolic MAC array. It reads weight groups and feature beats out of the weight and data buffers and drives the MAC control's input protocol: `wt_vld`/`wt`/`wt_cnt`, `dat_vld`/`dat`, and `Wout_loop_start`/`Wout_loop_end`. For each output-channel tile it sends one weight group of TOUT beats, then one Wout loop of feature beats. It enforces the ordering the MAC weight double-buffer relies on.

## Interface
- TOUT, 32, weight beats per group (equals `Tout`)
- LOG2TOUT, 5, width of `wt_cnt`
- WT_DW, 256, weight beat width (`base_Tin*MAX_WT_DW`)
- DAT_DW, 256, feature beat width (`base_Tin*MAX_DAT_DW`)
- AW, 12, buffer address width
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job start; ignored while busy
- tile_num  in  16  weight groups / Wout loops in the job; sampled at start
- wout_num  in  AW  feature beats per Wout loop; sampled at start
- wt_base, dat_base  in  AW each  buffer base addresses; sampled at start
- acc_rdy  in  1  downstream accumulator can accept a new Wout loop
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- wt_rd_en  out  1  weight buffer read; data returns 1 cycle later
- wt_rd_addr  out  AW  weight buffer address
- wt_rd_data  in  WT_DW  weight buffer read data
- dat_rd_en  out  1  data buffer read; data returns 1 cycle later
- dat_rd_addr  out  AW  data buffer address
- dat_rd_data  in  DAT_DW  data buffer read data
- wt_vld, wt, wt_cnt  out  1 / WT_DW / LOG2TOUT  weight beat to MAC
- dat_vld, dat  out  1 / DAT_DW  feature beat to MAC
- Wout_loop_start, Wout_loop_end  out  1 each  first-beat and last-beat markers

## Operation
- Top FSM has three states:
  - IDLE: goes to RUN on `start` when `tile_num`≠0. If `tile_num`==0, it pulses `done` next cycle and stays in IDLE.
  - RUN: both issuers active.
  - DRAIN: waits one cycle for the last read to return, then pulses `done` and returns to IDLE.
- Weight issuer: counter `wc` 0..TOUT-1 and group counter `wg`.
  - Reads `wt_base + wg*TOUT + wc`, strictly incrementing across the job.
  - The beat registered from the read carries `wt_cnt = wc`.
  - A group issues back-to-back with no gaps.
- Data issuer: beat counter `dc` 0..wout_num-1 and tile counter `dg`.
  - Reads `dat_base + dc`; the address restarts at `dat_base` for every tile.
  - Beat 0 carries `Wout_loop_start`; beat wout_num-1 carries `Wout_loop_end`. Both are set when wout_num==1.
  - A loop issues back-to-back.
- Ordering rules:
  - Loop k may start only after the last read of weight group k has issued, `acc_rdy`=1, and loop k-1 has fully issued.
  - Group k+1 may start only after the start read of loop k has issued. At most one group is outstanding ahead of its loop.
  - `acc_rdy` is sampled only at loop start; a loop in flight is never paused.
- RUN goes to DRAIN when the last read of loop `tile_num-1` issues.
- `busy` = state≠IDLE.

## Timing
- Reset values: every output is 0, FSM in IDLE, all counters 0.
- Reset asserted mid-job aborts immediately; no `done` is produced.
- Read-to-output latency is 1 cycle: an `*_rd_en` asserted in cycle t gives `*_vld` and its sideband in cycle t+1.
- `wt`/`dat` are `*_rd_data` registered pass-through.
- With `start` in cycle 0:
  - weight reads run in cycles 1..TOUT;
  - the first data read is in cycle TOUT+1 if `acc_rdy`=1;
  - `Wout_loop_start` appears in cycle TOUT+2.
- `done` comes 2 cycles after the final data read, i.e. 1 cycle after the final `Wout_loop_end`.
- The weight and data issuers may read in the same cycle because the ports are separate.
- A `start` asserted in the same cycle as `done` is ignored.

## Configuration
- `MAC_FEED_WT_PREFETCH_EN` defined: group k+1 issues overlapped with loop k, as in the ordering rules above.
- Undefined: group k+1 may start only after the `Wout_loop_end` read of loop k. Weights and data never overlap, and each tile after the first costs TOUT extra cycles.
- Reset values and protocol markers are the same in both builds.

## Test plan
- TOUT=4, tile_num=1, wout_num=3, acc_rdy=1, start at cycle 0:
  - `wt_vld` in cycles 2..5 with `wt_cnt` 0,1,2,3;
  - `dat_vld` in cycles 6..8, start in 6, end in 8;
  - `done` in cycle 9.
- TOUT=4, tile_num=3, wout_num=8, prefetch on:
  - group 1 weight reads begin the cycle after loop 0's first read;
  - weight addresses 0..11 contiguous;
  - data addresses restart at `dat_base` for each loop.
- Same job with prefetch off: no cycle has both `wt_vld` and `dat_vld`; total time grows by 8 cycles.
- wout_num=1: `Wout_loop_start` and `Wout_loop_end` are high on the same single beat for every tile.
- `acc_rdy` low for 10 cycles while group 0 is loaded: the first data read is delayed exactly 10 cycles, weight group 1 does not start, and no output is high in between.
- Reset mid-loop: all outputs drop to 0 asynchronously and no `done` is seen. Then tile_num=0 with `start` gives `done` one cycle later with no reads.
